// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - start/busy/done operand and result bundle for muldiv_unit
interface muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, input busy, done, div0, hi, lo);
  modport slave  (input start, op, a, b, output busy, done, div0, hi, lo);
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative signed/unsigned multiply/divide engine feeding HI/LO
// Works on magnitudes for WIDTH cycles, then applies the result signs in one fixup cycle.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic    clk_i,
  input  logic    rst_ni,
  muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic               is_div_q, is_div_d;
  logic               neg_q, neg_d;
  logic               rneg_q, rneg_d;
  logic [WIDTH-1:0]   opa_q, opa_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   rem_q, rem_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;
  logic               done_q, done_d;
  logic               div0_q, div0_d;

  logic               sa, sb;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     trial, diff;
  logic               q_bit;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // op[0] == 0 selects the signed variants (MULT, DIV)
  assign sa    = ~bus.op[0] & bus.a[WIDTH-1];
  assign sb    = ~bus.op[0] & bus.b[WIDTH-1];
  assign mag_a = sa ? -bus.a : bus.a;
  assign mag_b = sb ? -bus.b : bus.b;

  assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opa_q} : '0);

  // Restoring step: a set trial MSB always exceeds the WIDTH-bit divisor
  assign trial = {rem_q, acc_q[WIDTH-1]};
  assign diff  = trial - {1'b0, opa_q};
  assign q_bit = trial[WIDTH] | ~diff[WIDTH];

  assign prod_fix = neg_q ? -acc_q : acc_q;
  assign quo_fix  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = rneg_q ? -rem_q : rem_q;

  always_comb begin
    state_d  = state_q;
    is_div_d = is_div_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    opa_d    = opa_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    div0_d   = div0_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          is_div_d = bus.op[1];
          neg_d    = sa ^ sb;
          rneg_d   = sa;
          div0_d   = 1'b0;
          cnt_d    = '0;
          rem_d    = '0;
          if (bus.op[1] && (bus.b == '0)) begin
            done_d = 1'b1;
            div0_d = 1'b1;
          end else begin
            state_d = S_CALC;
            if (bus.op[1]) begin
              opa_d = mag_b;
              acc_d = {{WIDTH{1'b0}}, mag_a};
            end else begin
              opa_d = mag_a;
              acc_d = {{WIDTH{1'b0}}, mag_b};
            end
          end
        end
      end
      S_CALC: begin
        if (is_div_q) begin
          rem_d = q_bit ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
          acc_d = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-2:0], q_bit};
        end else begin
          acc_d = {mul_sum, acc_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end
      S_FIX: begin
        if (is_div_q) begin
          hi_d = rem_fix;
          lo_d = quo_fix;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      is_div_q <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      opa_q    <= '0;
      acc_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      is_div_q <= is_div_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      opa_q    <= opa_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
    end
  end

  assign bus.busy = (state_q != S_IDLE);
  assign bus.done = done_q;
  assign bus.div0 = div0_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;
endmodule
